// File: rtl/gdp.sv
// Sequential triangular-number engine: sum = 1 + 2 + ... + n (mod 2^WIDTH),
// built from a down-counter, an accumulator and a three-state controller.
module gdp #(
  parameter int WIDTH = 8
) (
  output logic [WIDTH-1:0] sum,
  input  logic             start,
  input  logic             restart,
  input  logic             clk,
  input  logic [WIDTH-1:0] nIn,
  output logic             displayRes
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ADD  = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t           state_r;
  state_t           state_s;
  logic [WIDTH-1:0] cnt_r;
  logic [WIDTH-1:0] cnt_s;
  logic [WIDTH-1:0] acc_r;
  logic [WIDTH-1:0] acc_s;
  logic             done_r;

  // Next-state and datapath update; DONE only releases once start is seen low.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    acc_s   = acc_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          cnt_s   = nIn;
          acc_s   = {WIDTH{1'b0}};
          state_s = ADD;
        end else begin
          state_s = IDLE;
        end
      end
      ADD: begin
        if (cnt_r != {WIDTH{1'b0}}) begin
          acc_s   = acc_r + cnt_r;
          cnt_s   = cnt_r - {{(WIDTH-1){1'b0}}, 1'b1};
          state_s = ADD;
        end else begin
          state_s = DONE;
        end
      end
      DONE: begin
        if (start) begin
          state_s = DONE;
        end else begin
          state_s = IDLE;
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = {WIDTH{1'b0}};
        acc_s   = {WIDTH{1'b0}};
      end
    endcase
  end

  // State, datapath and done-flag registers with asynchronous clear.
  always_ff @(posedge clk or posedge restart) begin
    if (restart) begin
      state_r <= IDLE;
      cnt_r   <= {WIDTH{1'b0}};
      acc_r   <= {WIDTH{1'b0}};
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      acc_r   <= acc_s;
      done_r  <= (state_s == DONE);
    end
  end

  assign sum        = acc_r;
  assign displayRes = done_r;

endmodule

// File: tb/tb_gdp.sv
// Randomized self-checking bench for gdp against a closed-form triangular-sum model.
module tb_gdp;

  localparam int W = 8;

  logic         clk;
  logic         restart;
  logic         start;
  logic [W-1:0] nIn;
  logic [W-1:0] sum;
  logic         displayRes;

  int n_checks;
  int n_fail;

  gdp #(.WIDTH(W)) dut (
    .sum        (sum),
    .start      (start),
    .restart    (restart),
    .clk        (clk),
    .nIn        (nIn),
    .displayRes (displayRes)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int tri_sum(input int n);
    return ((n * (n + 1)) / 2) % (1 << W);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full computation: hold_cycles>0 keeps start high through DONE that long.
  task automatic run_op(input int n, input int hold_cycles, input bit scramble);
    int lat;
    logic [W-1:0] final_sum;
    start = 1'b1;
    nIn   = n[W-1:0];
    step();
    lat = -1;
    for (int k = 1; k <= 300; k++) begin
      if (scramble) begin
        start = 1'($urandom_range(0, 1));
        nIn   = W'($urandom);
      end else begin
        start = (hold_cycles > 0) ? 1'b1 : 1'b0;
      end
      step();
      if (displayRes) begin
        lat = k;
        break;
      end
    end
    check_eq($sformatf("latency n=%0d", n), lat, n + 1);
    check_eq($sformatf("sum n=%0d", n), {24'd0, sum}, tri_sum(n));
    final_sum = W'(tri_sum(n));
    start = (hold_cycles > 0) ? 1'b1 : 1'b0;
    for (int h = 0; h < hold_cycles; h++) begin
      step();
      check_eq("hold done", {31'd0, displayRes}, 32'd1);
      check_eq("hold sum", {24'd0, sum}, {24'd0, final_sum});
    end
    start = 1'b0;
    step();
    check_eq("idle done low", {31'd0, displayRes}, 32'd0);
    check_eq("idle sum held", {24'd0, sum}, {24'd0, final_sum});
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    restart  = 1'b1;
    start    = 1'b0;
    nIn      = '0;
    #1;
    check_eq("reset sum", {24'd0, sum}, 32'd0);
    check_eq("reset done", {31'd0, displayRes}, 32'd0);
    step();
    step();
    #2 restart = 1'b0;
    step();
    check_eq("idle after reset", {31'd0, displayRes}, 32'd0);

    run_op(128, 0, 1'b0);
    run_op(5, 0, 1'b0);
    run_op(0, 0, 1'b0);
    run_op(255, 0, 1'b0);

    // Asynchronous abort in the middle of a long computation.
    start = 1'b1;
    nIn   = 8'd100;
    step();
    start = 1'b0;
    for (int i = 0; i < 20; i++) step();
    check_eq("partial nonzero", {31'd0, (sum != 8'd0)}, 32'd1);
    #2 restart = 1'b1;
    #1;
    check_eq("abort sum", {24'd0, sum}, 32'd0);
    check_eq("abort done", {31'd0, displayRes}, 32'd0);
    start = 1'b1;
    step();
    check_eq("reset hold sum", {24'd0, sum}, 32'd0);
    check_eq("reset hold done", {31'd0, displayRes}, 32'd0);
    #2 restart = 1'b0;
    run_op(3, 0, 1'b0);

    run_op(7, 5, 1'b0);

    for (int r = 0; r < 25; r++) begin
      int n;
      n = (r % 5 == 4) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 40));
      run_op(n, int'($urandom_range(0, 3)), 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/gdp.md
GDP -- requirements
Module: GDP

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, the operand and result width in bits.
REQ-002 The module SHALL have port clk, input, 1 bit, the single clock; all state updates occur on its rising edge.
REQ-003 The module SHALL have port restart, input, 1 bit, an asynchronous active-high reset.
REQ-004 The module SHALL have port start, input, 1 bit, an active-high request to begin a computation.
REQ-005 The module SHALL have port nIn, input, WIDTH bits, operand n, interpreted as unsigned.
REQ-006 The module SHALL have port sum, output, WIDTH bits, the registered accumulator value.
REQ-007 The module SHALL have port displayRes, output, 1 bit, the done flag; it is high only while sum holds a final result.
REQ-008 The positional port order SHALL be: sum, start, restart, clk, nIn, displayRes.

Function
REQ-009 The module SHALL compute sum = (1 + 2 + ... + n) mod 2^WIDTH, where n is nIn sampled at start acceptance.
REQ-010 The module SHALL implement an FSM with three states: IDLE, ADD and DONE.
REQ-011 State registers SHALL be a down-counter cnt (WIDTH bits), the accumulator acc (WIDTH bits, driving sum) and the FSM state.
REQ-012 In IDLE with start=1, the module SHALL at the next clock edge load cnt<=nIn and acc<=0, and enter ADD.
REQ-013 In IDLE with start=0, the module SHALL hold all registers.
REQ-014 In ADD with cnt!=0, each clock edge SHALL perform acc<=acc+cnt (wrap mod 2^WIDTH, carry discarded) and cnt<=cnt-1, and remain in ADD.
REQ-015 In ADD with cnt==0, the module SHALL go to DONE at the next edge and leave acc unchanged.
REQ-016 start and nIn SHALL be ignored while in ADD; nIn changes after acceptance SHALL NOT affect the result.
REQ-017 displayRes SHALL be a registered output, 1 exactly when the state is DONE, and 0 otherwise.
REQ-018 Latency SHALL be as follows: if the acceptance edge is edge 0, displayRes rises after edge n+1.
REQ-019 In DONE, sum SHALL hold the final value and displayRes SHALL stay 1 while start=1.
REQ-020 In DONE with start=0, the module SHALL return to IDLE at the next edge; sum is held and displayRes falls.
REQ-021 A new computation SHALL require start to be sampled 0 and then 1, so a held-high start never re-triggers.
REQ-022 sum SHALL show the partial accumulator during ADD; it is valid only while displayRes=1.
REQ-023 For n=0, the module SHALL give sum=0 with displayRes high after edge 1.

Reset
REQ-024 While restart=1, the module SHALL immediately, without waiting for clk, force state=IDLE, acc=0, cnt=0, sum=0 and displayRes=0.
REQ-025 The module SHALL hold these reset values for as long as restart=1; start SHALL be ignored during reset.
REQ-026 A restart assertion mid-ADD or in DONE SHALL abort the operation, with no partial result retained.
REQ-027 After restart deasserts, the first edge with start=1 in IDLE SHALL begin a computation.

Verification
REQ-028 The bench SHALL apply nIn=128 (0x80, equal to -128 as an 8-bit pattern) with a start pulse, and check: displayRes rises after edge 129, sum=64 (8256 mod 256).
REQ-029 The bench SHALL apply nIn=5, and check: sum=15, displayRes high after edge 6; then drop start and check the return to IDLE with sum still 15.
REQ-030 The bench SHALL apply nIn=0, and check: sum=0, displayRes high after edge 1.
REQ-031 The bench SHALL apply nIn=255, and check: sum=128 (32640 mod 256), displayRes high after edge 256.
REQ-032 The bench SHALL assert restart asynchronously mid-ADD with nIn=100, and check: sum=0 and displayRes=0 immediately; a following start with nIn=3 gives sum=6.
REQ-033 The bench SHALL hold start=1 through DONE, and check: no re-computation, displayRes stays 1, and sum is stable.
